// File: rtl/mult_mant_seq_pkg.sv
// Shared types for the single-precision mantissa multiplier: rounding mode and multiplier FSM state.
package mult_mant_seq_pkg;

    localparam int unsigned MANT_W = 24;

    typedef enum logic [2:0] {
        IEEE_near,
        IEEE_zero,
        IEEE_pinf,
        IEEE_ninf,
        near_up,
        away_zero
    } round_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mult_normalize.sv
// Single-position normalization of a 2*MANT_W-bit significand product into mantissa,
// guard and sticky for the rounder.
module mult_normalize #(
    parameter int unsigned MANT_W = 24
) (
    input  logic [2*MANT_W-1:0] prod_i,
    output logic [MANT_W-1:0]   mant_o,
    output logic                guard_o,
    output logic                sticky_o,
    output logic                norm_shift_o
);

    localparam int unsigned ProdW = 2 * MANT_W;

    always_comb begin
        norm_shift_o = prod_i[ProdW-1];
        if (prod_i[ProdW-1]) begin
            mant_o   = prod_i[ProdW-1:MANT_W];
            guard_o  = prod_i[MANT_W-1];
            sticky_o = |prod_i[MANT_W-2:0];
        end else begin
            // Product in [1,2): drop the always-zero MSB; denormal inputs stay unnormalized.
            mant_o   = prod_i[ProdW-2:MANT_W-1];
            guard_o  = prod_i[MANT_W-2];
            sticky_o = |prod_i[MANT_W-3:0];
        end
    end

endmodule

// File: rtl/mult_mant_seq.sv
// Radix-2 shift-add significand multiplier: one partial product per cycle, result held for
// the rounder until it is accepted.
module mult_mant_seq
    import mult_mant_seq_pkg::*;
#(
    parameter int unsigned MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] a_mant,
    input  logic [MANT_W-1:0] b_mant,
    input  logic              a_sign,
    input  logic              b_sign,
    input  round_t            rnd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mantissa,
    output logic              guard_bit,
    output logic              sticky_bit,
    output logic              calculated_sign,
    output round_t            rnd,
    output logic              norm_shift
);

    localparam int unsigned ProdW = 2 * MANT_W;
    localparam int unsigned CntW  = $clog2(MANT_W);

    mult_state_t       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ProdW-1:0]  acc_q, acc_d;
    logic [MANT_W-1:0] mcand_q, mcand_d;
    logic [MANT_W-1:0] mlr_q, mlr_d;
    logic              sign_q, sign_d;
    round_t            rnd_q, rnd_d;

    logic [MANT_W-1:0] addend;
    logic [MANT_W:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mlr_q   <= '0;
            sign_q  <= 1'b0;
            rnd_q   <= IEEE_near;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mlr_q   <= mlr_d;
            sign_q  <= sign_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mlr_d   = mlr_q;
        sign_d  = sign_q;
        rnd_d   = rnd_q;
        addend  = mlr_q[0] ? mcand_q : '0;
        sum     = {1'b0, acc_q[ProdW-1:MANT_W]} + {1'b0, addend};

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a_mant;
                    mlr_d   = b_mant;
                    sign_d  = a_sign ^ b_sign;
                    rnd_d   = rnd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    // A zero operand leaves the cleared accumulator as the final product.
                    state_d = ((a_mant == '0) || (b_mant == '0)) ? DONE : BUSY;
                end
            end
            BUSY: begin
                // Add into the upper half, then shift the carry in from the top.
                acc_d = {sum, acc_q[MANT_W-1:1]};
                mlr_d = mlr_q >> 1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(MANT_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready        = (state_q == IDLE);
    assign out_valid       = (state_q == DONE);
    assign calculated_sign = sign_q;
    assign rnd             = rnd_q;

    mult_normalize #(
        .MANT_W(MANT_W)
    ) u_normalize (
        .prod_i      (acc_q),
        .mant_o      (mantissa),
        .guard_o     (guard_bit),
        .sticky_o    (sticky_bit),
        .norm_shift_o(norm_shift)
    );

    // The rounder samples these whenever out_valid is high, so they must not move in DONE.
    a_done_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == DONE && !out_ready) |=> (state_q == DONE && $stable(acc_q)
                                             && $stable(sign_q) && $stable(rnd_q)));

    a_busy_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BUSY) |-> (cnt_q <= CntW'(MANT_W - 1)));

endmodule

// File: doc/mult_mant_seq.md
# mult_mant_seq

Iterative (radix-2 shift-add) mantissa multiplier for the FPU single-precision multiply path. It accepts two 24-bit significands with hidden bits through a valid/ready handshake and computes the 48-bit product over 24 cycles. It normalizes the product by at most one position and presents `mantissa`, `guard_bit`, `sticky_bit`, `calculated_sign` and `rnd` directly to `round_mult`. It is the producer side of the rounder's input interface, and also supplies the exponent-increment flag to the exponent logic.

## Interface
- `MANT_W`, default 24: significand width including hidden bit; product width 2*MANT_W.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operand presented.
- `in_ready` out 1: block idle, can accept.
- `a_mant`, `b_mant` in MANT_W: significands, hidden bit at MSB.
- `a_sign`, `b_sign` in 1: operand signs.
- `rnd_in` in `round_t`: rounding mode, captured with operands.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts result.
- `mantissa` out MANT_W: normalized significand to rounder.
- `guard_bit` out 1: first bit below `mantissa` LSB.
- `sticky_bit` out 1: OR of all bits below the guard bit.
- `calculated_sign` out 1: `a_sign ^ b_sign`.
- `rnd` out `round_t`: captured `rnd_in`.
- `norm_shift` out 1: product MSB was set; the exponent adds 1.

## Operation
- FSM states:
  - IDLE: reset state. `in_ready` = 1, combinational from state, so it is 1 during and after reset.
  - BUSY: 24 iterations; counter 0..MANT_W-1.
  - DONE: `out_valid` = 1.
- IDLE, `in_valid` & `in_ready`:
  - Latch the operands, sign XOR and `rnd_in`.
  - Clear the 2*MANT_W accumulator and the counter.
  - If `a_mant` == 0 or `b_mant` == 0, go directly to DONE with a zero product. Otherwise go to BUSY.
- BUSY, each cycle:
  - If multiplier LSB = 1, add the multiplicand into the accumulator upper half with carry.
  - Shift accumulator and multiplier right by 1; increment the counter.
  - At counter = MANT_W-1, go to DONE.
- Normalization, combinational on the final product P[47:0]:
  - P[47] = 1: `mantissa` = P[47:24], `guard_bit` = P[23], `sticky_bit` = |P[22:0], `norm_shift` = 1.
  - P[47] = 0: `mantissa` = P[46:23], `guard_bit` = P[22], `sticky_bit` = |P[21:0], `norm_shift` = 0.
  - No further shift. Denormal operands yield an unnormalized `mantissa`, which downstream handles.
- DONE: hold every output stable until `out_valid` & `out_ready`, then go to IDLE.
- `in_ready` = 0 in BUSY and DONE; new operands are ignored there.
- Reset values:
  - State IDLE; counter 0; accumulator 0.
  - `out_valid` 0, `mantissa` 0, `guard_bit` 0, `sticky_bit` 0, `calculated_sign` 0, `norm_shift` 0, `rnd` = `IEEE_near`.

## Timing
- Acceptance on edge T:
  - Nonzero operands: BUSY during edges T+1..T+24; `out_valid` high from the cycle after edge T+24.
  - Zero operand: `out_valid` high from the cycle after edge T.
- Result handshake on edge R: `out_valid` low and `in_ready` high in the cycle after R.
- Minimum issue interval: 26 cycles nonzero, 2 cycles zero.
- Outputs are registered (normalization acts on registered P) and stable for the whole DONE state. `out_ready` may be held low indefinitely.
- Reset asserted mid-BUSY or mid-DONE: immediate return to reset values. The in-flight operation is discarded; no partial result appears.
- `in_valid` high while not IDLE: no effect; the operand must be held by the source until `in_ready`.

## Structure
- `round_t` and its `IEEE_near` reset value stay in shared `typedef.svh`.
- Add `MANT_W` and a state enum `mult_state_t` (IDLE, BUSY, DONE) to the same package.
- One sub-module, `mult_normalize`: combinational P -> {`mantissa`, `guard_bit`, `sticky_bit`, `norm_shift`}, reusable by a future pipelined multiplier.

## Test plan
- `a` = `b` = 24'h800000 (1.0×1.0) -> `mantissa` 24'h800000, guard 0, sticky 0, `norm_shift` 0; `out_valid` 24 cycles after acceptance.
- `a` = `b` = 24'hC00000 (1.5×1.5, P = 48'h900000000000) -> `mantissa` 24'h900000, guard 0, sticky 0, `norm_shift` 1.
- `a` = `b` = 24'hFFFFFF (P = 48'hFFFFFE000001) -> `mantissa` 24'hFFFFFE, guard 0, sticky 1, `norm_shift` 1.
- `a` = 0, `b` = 24'hABCDEF, `a_sign` = 1, `rnd_in` = `away_zero` -> `out_valid` 1 cycle after acceptance; all result bits 0; `calculated_sign` 1; `rnd` = `away_zero`.
- Hold `out_ready` low 10 cycles in DONE -> outputs unchanged and `in_ready` 0 throughout. Pulse `out_ready` -> `in_ready` 1 next cycle. Back-to-back operands are accepted correctly.
- Drop `rst_n` at BUSY iteration 10 -> all outputs at reset values immediately, `in_ready` 1. After reset, a new 1.0×1.0 operation completes normally.
